// File: rtl/arbitro_salida_rr_if.sv
// Bus bundle for the round-robin output arbiter: FIFO heads/pops, merged
// stream and counter readout. master = arbiter side, slave = environment side.
interface arbitro_salida_rr_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 5
);
  logic [DATA_W-1:0] fifo_data0;
  logic [DATA_W-1:0] fifo_data1;
  logic [DATA_W-1:0] fifo_data2;
  logic [DATA_W-1:0] fifo_data3;
  logic [3:0]        fifo_empty;
  logic [3:0]        pop;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        chan_out;
  logic              valid_out;
  logic              req;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  cnt_out;
  logic              cnt_valid;

  modport master (
    input  fifo_data0, fifo_data1, fifo_data2, fifo_data3, fifo_empty, req, idx,
    output pop, data_out, chan_out, valid_out, cnt_out, cnt_valid
  );

  modport slave (
    output fifo_data0, fifo_data1, fifo_data2, fifo_data3, fifo_empty, req, idx,
    input  pop, data_out, chan_out, valid_out, cnt_out, cnt_valid
  );
endinterface

// File: rtl/arbitro_salida_rr.sv
// Round-robin consumer of four output FIFOs: one pop per cycle, merged and
// channel-tagged registered stream, saturating per-channel and total counters.
module arbitro_salida_rr #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 5
) (
  input logic                clk,
  input logic                reset,
  input logic                init,
  arbitro_salida_rr_if.master bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        grant;
  logic              found;
  logic [3:0]        pop;
  logic [DATA_W-1:0] head [4];
  logic [DATA_W-1:0] data_q;
  logic [1:0]        chan_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  rd_val;
  logic [CNT_W-1:0]  cnt_out_q;
  logic              cnt_valid_q;

  assign head[0] = bus.fifo_data0;
  assign head[1] = bus.fifo_data1;
  assign head[2] = bus.fifo_data2;
  assign head[3] = bus.fifo_data3;

  // First non-empty FIFO at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && !bus.fifo_empty[rr_ptr_q + 2'(i)]) begin
        found = 1'b1;
        grant = rr_ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    inflight_d = 1'b0;
    pop        = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.fifo_empty != 4'b1111) state_d = StActive;
      end
      StActive: begin
        if (found) begin
          pop[grant] = 1'b1;
          rr_ptr_d   = grant + 2'd1;
          sel_d      = grant;
          inflight_d = 1'b1;
        end else if (!inflight_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // init wins over a same-cycle increment.
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    if (init) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
      total_d = '0;
    end else if (valid_q) begin
      if (cnt_q[chan_q] != CntMax) cnt_d[chan_q] = cnt_q[chan_q] + CntOne;
      if (total_q != CntMax) total_d = total_q + CntOne;
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.idx < 3'd4) rd_val = cnt_q[bus.idx[1:0]];
    else if (bus.idx == 3'd4) rd_val = total_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      inflight_q  <= 1'b0;
      data_q      <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      total_q     <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      inflight_q <= inflight_d;
      valid_q    <= inflight_q;
      // The popped word reaches the FIFO head one cycle after its pop.
      if (inflight_q) begin
        data_q <= head[sel_q];
        chan_q <= sel_q;
      end
      total_q <= total_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      cnt_valid_q <= bus.req;
      if (bus.req) cnt_out_q <= rd_val;
    end
  end

  assign bus.pop       = pop;
  assign bus.data_out  = data_q;
  assign bus.chan_out  = chan_q;
  assign bus.valid_out = valid_q;
  assign bus.cnt_out   = cnt_out_q;
  assign bus.cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_arbitro_salida_rr.sv
// Directed bench for arbitro_salida_rr: FIFO models with one-cycle read
// latency, stream collection and counter readback against hand-computed values.
module tb_arbitro_salida_rr;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CNT_W  = 5;

  logic clk = 1'b0;
  logic reset;
  logic init;

  arbitro_salida_rr_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  arbitro_salida_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];
  int total = 0;
  int bad   = 0;

  logic [3:0]        s_pop, s_empty;
  logic              s_valid, s_cv;
  logic [DATA_W-1:0] s_data;
  logic [1:0]        s_chan;
  logic [CNT_W-1:0]  s_co;

  logic [DATA_W-1:0] got_d[$];
  logic [1:0]        got_c[$];
  int                first_pop, first_valid, last_valid, ncyc, npop;
  logic [3:0]        first_pop_val, pop_or;
  int                init_nth = 0;
  int                init_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    bus.fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] v);
    case (ch)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
    upd_empty();
  endtask

  task automatic clear_rec();
    got_d.delete();
    got_c.delete();
    first_pop = -1; first_valid = -1; last_valid = -1;
    ncyc = 0; npop = 0; first_pop_val = '0; pop_or = '0;
  endtask

  // One clock: sample at negedge, then model FIFO pops just after the edge.
  task automatic cyc();
    @(negedge clk);
    s_pop = bus.pop; s_empty = bus.fifo_empty; s_valid = bus.valid_out;
    s_data = bus.data_out; s_chan = bus.chan_out; s_cv = bus.cnt_valid; s_co = bus.cnt_out;
    if (init_nth > 0) begin
      if (s_valid) init_seen++;
      init = s_valid && (init_seen == init_nth);
    end
    chk("pop_onehot", 32'($onehot0(s_pop)), 32'd1);
    chk("pop_nonempty", {28'd0, s_pop & s_empty}, 32'd0);
    if (s_pop != 4'd0) begin
      if (first_pop < 0) begin first_pop = ncyc; first_pop_val = s_pop; end
      npop++;
      pop_or |= s_pop;
    end
    if (s_valid) begin
      if (first_valid < 0) first_valid = ncyc;
      last_valid = ncyc;
      got_d.push_back(s_data);
      got_c.push_back(s_chan);
    end
    ncyc++;
    @(posedge clk);
    #1;
    if (init_nth > 0) init = 1'b0;
    if (s_pop[0]) bus.fifo_data0 = q0.pop_front();
    if (s_pop[1]) bus.fifo_data1 = q1.pop_front();
    if (s_pop[2]) bus.fifo_data2 = q2.pop_front();
    if (s_pop[3]) bus.fifo_data3 = q3.pop_front();
    upd_empty();
  endtask

  task automatic read_cnt(input logic [2:0] i, input logic [CNT_W-1:0] exp, input string tag);
    bus.req = 1'b1;
    bus.idx = i;
    cyc();
    bus.req = 1'b0;
    cyc();
    chk({tag, "_valid"}, 32'(s_cv), 32'd1);
    chk(tag, 32'(s_co), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; bus.req = 1'b0; bus.idx = '0;
    bus.fifo_data0 = '0; bus.fifo_data1 = '0; bus.fifo_data2 = '0; bus.fifo_data3 = '0;
    upd_empty();
    clear_rec();
    #1;
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_chan", 32'(bus.chan_out), 32'd0);
    chk("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    chk("rst_cnt_out", 32'(bus.cnt_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: reset in the middle of a stream
    for (int ch = 0; ch < 4; ch++)
      for (int j = 0; j < 4; j++) push(ch, 12'(512 + ch * 16 + j));
    bus.req = 1'b1; bus.idx = 3'd4;
    repeat (6) cyc();
    chk("t1_streaming", 32'(s_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_pop", 32'(bus.pop), 32'd0);
    chk("t1_rst_valid", 32'(bus.valid_out), 32'd0);
    chk("t1_rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    chk("t1_rst_data", 32'(bus.data_out), 32'd0);
    bus.req = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    clear_rec();
    read_cnt(3'd4, 5'd0, "t1_total_after_rst");
    repeat (25) cyc();
    chk("t1_first_grant", 32'(first_pop_val), 32'b0001);
    chk("t1_words_after_rst", got_d.size(), 32'd11);
    init = 1'b1; cyc(); init = 1'b0;

    // 2: round-robin fairness, 3 words per channel
    for (int j = 0; j < 3; j++)
      for (int ch = 0; ch < 4; ch++) push(ch, 12'(256 + ch * 16 + j));
    clear_rec();
    repeat (25) cyc();
    chk("t2_count", got_d.size(), 32'd12);
    for (int i = 0; i < 12 && i < got_d.size(); i++) begin
      chk("t2_chan", 32'(got_c[i]), 32'(i % 4));
      chk("t2_data", 32'(got_d[i]), 32'(256 + (i % 4) * 16 + i / 4));
    end
    chk("t2_latency", first_valid - first_pop, 32'd2);
    chk("t2_continuous", last_valid - first_valid, 32'd11);
    read_cnt(3'd1, 5'd3, "t2_cnt1");
    read_cnt(3'd4, 5'd12, "t2_total");

    // 3: only FIFO 2 has data
    push(2, 12'h0A5); push(2, 12'h123);
    clear_rec();
    repeat (12) cyc();
    chk("t3_npop", npop, 32'd2);
    chk("t3_pop_bits", 32'(pop_or), 32'b0100);
    chk("t3_count", got_d.size(), 32'd2);
    if (got_d.size() == 2) begin
      chk("t3_data0", 32'(got_d[0]), 32'h0A5);
      chk("t3_data1", 32'(got_d[1]), 32'h123);
      chk("t3_chan0", 32'(got_c[0]), 32'd2);
      chk("t3_chan1", 32'(got_c[1]), 32'd2);
    end
    chk("t3_idle_pop", 32'(s_pop), 32'd0);
    chk("t3_idle_valid", 32'(s_valid), 32'd0);

    // 4: rr_ptr is 3, FIFO 3 empty -> grant wraps to 1, then ptr=2
    push(1, 12'h0B1);
    clear_rec();
    repeat (10) cyc();
    chk("t4_grant", 32'(first_pop_val), 32'b0010);
    chk("t4_count", got_c.size(), 32'd1);
    push(0, 12'h0C0); push(1, 12'h0C1); push(2, 12'h0C2);
    clear_rec();
    repeat (12) cyc();
    chk("t4_count2", got_c.size(), 32'd3);
    if (got_c.size() == 3) begin
      chk("t4_order0", 32'(got_c[0]), 32'd2);
      chk("t4_order1", 32'(got_c[1]), 32'd0);
      chk("t4_order2", 32'(got_c[2]), 32'd1);
    end
    read_cnt(3'd2, 5'd6, "t4_cnt2");
    read_cnt(3'd4, 5'd18, "t4_total");

    // 5: saturation
    init = 1'b1; cyc(); init = 1'b0;
    for (int j = 0; j < 34; j++) push(0, 12'(j));
    clear_rec();
    repeat (45) cyc();
    chk("t5_count", got_d.size(), 32'd34);
    read_cnt(3'd0, 5'd31, "t5_cnt0_sat");
    read_cnt(3'd4, 5'd31, "t5_total_sat");
    read_cnt(3'd6, 5'd0, "t5_reserved");
    read_cnt(3'd1, 5'd0, "t5_cnt1_cleared");

    // 6: init on the same cycle as the last increment of channel 1
    for (int j = 0; j < 3; j++) push(1, 12'(1792 + j));
    init_seen = 0;
    init_nth  = 3;
    clear_rec();
    repeat (12) cyc();
    init_nth = 0;
    init = 1'b0;
    chk("t6_count", got_d.size(), 32'd3);
    read_cnt(3'd1, 5'd0, "t6_cnt1_init");
    read_cnt(3'd4, 5'd0, "t6_total_init");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
